// File: rtl/spi_trace_tap.sv
// SPI probe front end for the logic-analyzer core: synchronizes the SPI pins,
// deserializes MOSI bytes and produces a 6-bit trace word plus a one-shot trigger.
module spi_trace_tap #(
    parameter logic [7:0] MATCH_BYTE  = 8'hA5,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       spi_sclk_i,
    input  logic       spi_cs_n_i,
    input  logic       spi_mosi_i,
    input  logic       spi_miso_i,
    input  logic       arm_i,
    output logic [5:0] trace_dout_o,
    output logic       trigger_out_o,
    output logic       trigger_en_o,
    output logic       byte_valid_o,
    output logic [7:0] byte_data_o
);

    typedef enum logic {IDLE, SHIFT} state_t;

    // Pin vector order {miso, mosi, cs_n, sclk}; idle level has only cs_n high.
    localparam logic [3:0] PIN_IDLE = 4'b0010;

    logic [3:0] pins_raw;
    logic [3:0] sync_q [SYNC_STAGES];
    logic       sclk_s, cs_n_s, mosi_s, miso_s;
    logic       sclk_d_q;
    logic       sclk_rise;

    state_t     state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shreg_q, shreg_d;
    logic       byte_valid_q, byte_valid_d;
    logic [7:0] byte_data_q, byte_data_d;
    logic       match_q, match_d;
    logic       armed_q, armed_d;
    logic [5:0] trace_q, trace_d;
    logic       trigger;

    assign pins_raw = {spi_miso_i, spi_mosi_i, spi_cs_n_i, spi_sclk_i};

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= PIN_IDLE;
            end
            sclk_d_q <= 1'b0;
        end else begin
            sync_q[0] <= pins_raw;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            sclk_d_q <= sclk_s;
        end
    end

    assign sclk_s    = sync_q[SYNC_STAGES-1][0];
    assign cs_n_s    = sync_q[SYNC_STAGES-1][1];
    assign mosi_s    = sync_q[SYNC_STAGES-1][2];
    assign miso_s    = sync_q[SYNC_STAGES-1][3];
    assign sclk_rise = sclk_s & ~sclk_d_q;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (!cs_n_s) state_d = SHIFT;
            SHIFT:   if (cs_n_s)  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Deassertion of cs_n takes priority over a coincident sclk edge.
    always_comb begin
        bit_cnt_d    = bit_cnt_q;
        shreg_d      = shreg_q;
        byte_valid_d = 1'b0;
        byte_data_d  = byte_data_q;
        match_d      = 1'b0;
        if (state_q == IDLE || cs_n_s) begin
            bit_cnt_d = 3'd0;
        end else if (sclk_rise) begin
            shreg_d   = {shreg_q[6:0], mosi_s};
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
                byte_valid_d = 1'b1;
                byte_data_d  = {shreg_q[6:0], mosi_s};
                match_d      = ({shreg_q[6:0], mosi_s} == MATCH_BYTE);
            end
        end
    end

    assign trigger = match_q & armed_q;
    assign armed_d = arm_i | (armed_q & ~trigger);
    assign trace_d = {match_q, byte_valid_q, miso_s, mosi_s, cs_n_s, sclk_s};

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            bit_cnt_q    <= 3'd0;
            shreg_q      <= 8'h00;
            byte_valid_q <= 1'b0;
            byte_data_q  <= 8'h00;
            match_q      <= 1'b0;
            armed_q      <= 1'b0;
            trace_q      <= 6'b000010;
        end else begin
            bit_cnt_q    <= bit_cnt_d;
            shreg_q      <= shreg_d;
            byte_valid_q <= byte_valid_d;
            byte_data_q  <= byte_data_d;
            match_q      <= match_d;
            armed_q      <= armed_d;
            trace_q      <= trace_d;
        end
    end

    assign trace_dout_o  = trace_q;
    assign trigger_out_o = trigger;
    assign trigger_en_o  = armed_q;
    assign byte_valid_o  = byte_valid_q;
    assign byte_data_o   = byte_data_q;

endmodule
